// File: rtl/fact_job_sched_pkg.sv
// Shared definitions for the factorial job scheduler:
// fact_top register map, status bits and FSM encoding.
package fact_job_sched_pkg;

  localparam logic [1:0] FACT_A_N    = 2'b00;
  localparam logic [1:0] FACT_A_GO   = 2'b01;
  localparam logic [1:0] FACT_A_STAT = 2'b10;
  localparam logic [1:0] FACT_A_RES  = 2'b11;

  localparam int FACT_STAT_DONE = 0;
  localparam int FACT_STAT_ERR  = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_N   = 3'd1,
    S_WR_GO  = 3'd2,
    S_POLL   = 3'd3,
    S_RD_RES = 3'd4,
    S_WR_CLR = 3'd5,
    S_RESP   = 3'd6
  } state_e;

endpackage

// File: rtl/fact_job_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first
// requester at or after ptr, wrapping to index 0.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id
);

  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j -= NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        gnt_id = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/fact_job_sched.sv
// Round-robin job scheduler driving the fact_top register
// protocol on behalf of NUM_REQ clients.
module fact_job_sched
  import fact_job_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int N_W          = 4,
  parameter int RES_W        = 32,
  parameter int POLL_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*N_W-1:0] req_n,
  output logic [NUM_REQ-1:0]     ack,
  output logic [RES_W-1:0]       rsp_result,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic [1:0]             acc_A,
  output logic                   acc_WE,
  output logic [N_W-1:0]         acc_WD,
  input  logic [RES_W-1:0]       acc_RD
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PCW = $clog2(POLL_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IDW-1:0]     cur_id_q, cur_id_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_W-1:0]     n_lat_q, n_lat_d;
  logic [RES_W-1:0]   res_lat_q, res_lat_d;
  logic               err_q, err_d;
  logic               to_q, to_d;
  logic [PCW-1:0]     poll_cnt_q, poll_cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic [N_W-1:0]     n_sel;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr_q),
    .gnt   (gnt),
    .gnt_id(gnt_id)
  );

  always_comb begin
    n_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) n_sel = n_sel | req_n[i*N_W +: N_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_id_q   <= '0;
      rr_ptr_q   <= '0;
      n_lat_q    <= '0;
      res_lat_q  <= '0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
      poll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      rr_ptr_q   <= rr_ptr_d;
      n_lat_q    <= n_lat_d;
      res_lat_q  <= res_lat_d;
      err_q      <= err_d;
      to_q       <= to_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    rr_ptr_d   = rr_ptr_q;
    n_lat_d    = n_lat_q;
    res_lat_d  = res_lat_q;
    err_d      = err_q;
    to_d       = to_q;
    poll_cnt_d = poll_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          cur_id_d  = gnt_id;
          n_lat_d   = n_sel;
          res_lat_d = '0;
          err_d     = 1'b0;
          to_d      = 1'b0;
          state_d   = S_WR_N;
        end
      end
      S_WR_N: state_d = S_WR_GO;
      S_WR_GO: begin
        poll_cnt_d = '0;
        state_d    = S_POLL;
      end
      S_POLL: begin
        if (acc_RD[FACT_STAT_DONE]) begin
          err_d   = acc_RD[FACT_STAT_ERR];
          state_d = S_RD_RES;
        end else if (poll_cnt_q == PCW'(POLL_TIMEOUT - 1)) begin
          to_d      = 1'b1;
          err_d     = 1'b1;
          res_lat_d = '0;
          state_d   = S_WR_CLR;
        end else if (poll_cnt_q != '1) begin
          poll_cnt_d = poll_cnt_q + PCW'(1);
        end
      end
      S_RD_RES: begin
        res_lat_d = acc_RD;
        state_d   = S_WR_CLR;
      end
      S_WR_CLR: state_d = S_RESP;
      S_RESP: begin
        rr_ptr_d = (cur_id_q == IDW'(NUM_REQ - 1)) ?
                   '0 : cur_id_q + IDW'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus signals are a pure decode of the registered state
  always_comb begin
    acc_A       = '0;
    acc_WE      = 1'b0;
    acc_WD      = '0;
    ack         = '0;
    rsp_result  = '0;
    rsp_err     = 1'b0;
    rsp_timeout = 1'b0;
    busy        = (state_q != S_IDLE);
    unique case (state_q)
      S_WR_N: begin
        acc_A  = FACT_A_N;
        acc_WE = 1'b1;
        acc_WD = n_lat_q;
      end
      S_WR_GO: begin
        acc_A  = FACT_A_GO;
        acc_WE = 1'b1;
        acc_WD = N_W'(1);
      end
      S_POLL:   acc_A = FACT_A_STAT;
      S_RD_RES: acc_A = FACT_A_RES;
      S_WR_CLR: begin
        acc_A  = FACT_A_GO;
        acc_WE = 1'b1;
      end
      S_RESP: begin
        ack[cur_id_q] = 1'b1;
        rsp_result    = res_lat_q;
        rsp_err       = err_q;
        rsp_timeout   = to_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fact_job_sched.sv
// Directed bench for fact_job_sched with a small
// behavioural fact_top register model.
module tb_fact_job_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [7:0]  req_n;
  logic [1:0]  ack;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [1:0]  acc_A;
  logic        acc_WE;
  logic [3:0]  acc_WD;
  logic [31:0] acc_RD;

  int total = 0;
  int passed = 0;

  fact_job_sched #(
    .NUM_REQ(2),
    .N_W(4),
    .RES_W(32),
    .POLL_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_n(req_n),
    .ack(ack),
    .rsp_result(rsp_result),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .busy(busy),
    .acc_A(acc_A),
    .acc_WE(acc_WE),
    .acc_WD(acc_WD),
    .acc_RD(acc_RD)
  );

  always #5 clk = ~clk;

  logic [3:0] m_n;
  logic       m_go;
  int         m_polls;
  int         dly = 1;
  logic [1:0] last_wa;
  logic [3:0] last_wd;
  logic       m_done;

  function automatic logic [31:0] fact32(input logic [3:0] n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * i;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n <= '0;
      m_go <= 1'b0;
      m_polls <= 0;
      last_wa <= '0;
      last_wd <= '0;
    end else if (acc_WE) begin
      if (acc_A == 2'b00) m_n <= acc_WD;
      if (acc_A == 2'b01) begin
        m_go <= acc_WD[0];
        m_polls <= 0;
      end
      last_wa <= acc_A;
      last_wd <= acc_WD;
    end else if (acc_A == 2'b10) begin
      m_polls <= m_polls + 1;
    end
  end

  always_comb begin
    m_done = m_go && (dly > 0) && (m_polls >= dly - 1);
    acc_RD = '0;
    if (acc_A == 2'b10)
      acc_RD = {30'd0, (m_n > 4'd12), m_done};
    else if (acc_A == 2'b11)
      acc_RD = fact32(m_n);
  end

  task automatic wait_ack(output int k);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (ack != 2'b00) break;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    req_n = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({ack, busy} !== 3'b000)
      $display("FAIL reset_ack_busy got %b want 000", {ack, busy});
    else passed++;
    total++;
    if ({acc_A, acc_WE, acc_WD} !== 7'd0)
      $display("FAIL reset_bus got %b want 0", {acc_A, acc_WE, acc_WD});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({rsp_result, rsp_err, rsp_timeout} !== 34'd0)
      $display("FAIL reset_rsp got %h want 0", {rsp_result, rsp_err, rsp_timeout});
    else passed++;
    total++;
    if (busy !== 1'b0)
      $display("FAIL idle_busy got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_single();
    int k;
    dly = 3;
    req_n = {4'd0, 4'd5};
    req = 2'b01;
    @(negedge clk);
    total++;
    if ({busy, acc_A, acc_WE, acc_WD} !== {1'b1, 2'b00, 1'b1, 4'd5})
      $display("FAIL wr_n_bus got %b want 1001_0101", {busy, acc_A, acc_WE, acc_WD});
    else passed++;
    wait_ack(k);
    k++;
    total++;
    if (k !== 8) $display("FAIL single_latency got %0d want 8", k);
    else passed++;
    total++;
    if (ack !== 2'b01) $display("FAIL single_ack got %b want 01", ack);
    else passed++;
    total++;
    if (rsp_result !== 32'd120)
      $display("FAIL single_result got %0d want 120", rsp_result);
    else passed++;
    total++;
    if ({rsp_err, rsp_timeout} !== 2'b00)
      $display("FAIL single_err got %b want 00", {rsp_err, rsp_timeout});
    else passed++;
    req = 2'b00;
    @(negedge clk);
    total++;
    if (ack !== 2'b00) $display("FAIL single_ack_pulse got %b want 00", ack);
    else passed++;
  endtask

  task automatic test_contention();
    int k;
    pulse_reset();
    dly = 1;
    req_n = {4'd6, 4'd4};
    req = 2'b11;
    wait_ack(k);
    total++;
    if (k !== 6) $display("FAIL cont_latency got %0d want 6", k);
    else passed++;
    total++;
    if (ack !== 2'b01) $display("FAIL cont_first_ack got %b want 01", ack);
    else passed++;
    total++;
    if (rsp_result !== 32'd24)
      $display("FAIL cont_first_result got %0d want 24", rsp_result);
    else passed++;
    req = 2'b10;
    wait_ack(k);
    total++;
    if (k !== 7) $display("FAIL cont_gap got %0d want 7", k);
    else passed++;
    total++;
    if (ack !== 2'b10) $display("FAIL cont_second_ack got %b want 10", ack);
    else passed++;
    total++;
    if (rsp_result !== 32'd720)
      $display("FAIL cont_second_result got %0d want 720", rsp_result);
    else passed++;
    req = 2'b00;
  endtask

  task automatic test_fairness();
    int k;
    logic [1:0] exp;
    dly = 1;
    req_n = {4'd3, 4'd2};
    req = 2'b11;
    for (int j = 0; j < 6; j++) begin
      exp = (j % 2 == 0) ? 2'b01 : 2'b10;
      wait_ack(k);
      total++;
      if (ack !== exp)
        $display("FAIL fair_job%0d got %b want %b", j, ack, exp);
      else passed++;
    end
    req = 2'b00;
  endtask

  task automatic test_overflow();
    int k;
    int cnt;
    @(negedge clk);
    dly = 2;
    req_n = {4'd0, 4'd13};
    req = 2'b01;
    wait_ack(k);
    total++;
    if (ack !== 2'b01) $display("FAIL ovf_ack got %b want 01", ack);
    else passed++;
    total++;
    if ({rsp_err, rsp_timeout} !== 2'b10)
      $display("FAIL ovf_err got %b want 10", {rsp_err, rsp_timeout});
    else passed++;
    req = 2'b00;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack != 2'b00) cnt++;
    end
    total++;
    if (cnt !== 0) $display("FAIL ovf_extra_acks got %0d want 0", cnt);
    else passed++;
  endtask

  task automatic test_timeout();
    int k;
    dly = 0;
    req_n = {4'd3, 4'd0};
    req = 2'b10;
    wait_ack(k);
    total++;
    if (k !== 12) $display("FAIL to_latency got %0d want 12", k);
    else passed++;
    total++;
    if (ack !== 2'b10) $display("FAIL to_ack got %b want 10", ack);
    else passed++;
    total++;
    if ({rsp_err, rsp_timeout} !== 2'b11)
      $display("FAIL to_flags got %b want 11", {rsp_err, rsp_timeout});
    else passed++;
    total++;
    if (rsp_result !== 32'd0)
      $display("FAIL to_result got %0d want 0", rsp_result);
    else passed++;
    total++;
    if ({last_wa, last_wd} !== {2'b01, 4'd0})
      $display("FAIL to_last_write got %b want 01_0000", {last_wa, last_wd});
    else passed++;
    req = 2'b00;
  endtask

  task automatic test_reset_in_poll();
    int k;
    int cnt;
    @(negedge clk);
    dly = 0;
    req_n = {4'd0, 4'd7};
    req = 2'b01;
    k = 0;
    while (k < 20 && acc_A !== 2'b10) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (acc_A !== 2'b10) $display("FAIL rip_reach_poll got %b want 10", acc_A);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, ack, acc_A, acc_WE, acc_WD} !== 10'd0)
      $display("FAIL rip_outputs got %b want 0", {busy, ack, acc_A, acc_WE, acc_WD});
    else passed++;
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack != 2'b00) cnt++;
    end
    total++;
    if (cnt !== 0) $display("FAIL rip_no_ack got %0d want 0", cnt);
    else passed++;
    dly = 2;
    req_n = {4'd0, 4'd4};
    req = 2'b01;
    wait_ack(k);
    total++;
    if (k !== 7) $display("FAIL rip_latency got %0d want 7", k);
    else passed++;
    total++;
    if ({ack, rsp_result} !== {2'b01, 32'd24})
      $display("FAIL rip_rejob got %b/%0d want 01/24", ack, rsp_result);
    else passed++;
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_overflow();
    test_timeout();
    test_reset_in_poll();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
